// File: rtl/wb_stage.sv
// Writeback stage of the 16-bit SIMPLE datapath: register-file write strobe,
// architectural flags, OUT port handshake, HLT handling and a retire counter.
module wb_stage #(
  parameter int         RF_AW  = 3,
  parameter logic [3:0] HLT_OP = 4'd15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       opcode,
  input  logic [16:0]      alu_result,
  input  logic             alu_s,
  input  logic             alu_z,
  input  logic             alu_c,
  input  logic             alu_v,
  input  logic [RF_AW-1:0] rd,
  input  logic             wb_en,
  input  logic             flag_en,
  input  logic             out_en,
  output logic             rf_we,
  output logic [RF_AW-1:0] rf_waddr,
  output logic [15:0]      rf_wdata,
  output logic [3:0]       flags,
  output logic [15:0]      out_data,
  output logic             out_valid,
  input  logic             out_ack,
  output logic             halted,
  output logic [15:0]      retire_count
);

  localparam logic [1:0] RUN      = 2'd0;
  localparam logic [1:0] OUT_WAIT = 2'd1;
  localparam logic [1:0] HALT     = 2'd2;

  logic [1:0] state;
  logic       accept;
  logic       is_hlt;
  logic       unused_result_msb;

  assign accept            = in_valid && in_ready;
  assign is_hlt            = (opcode == HLT_OP);
  assign unused_result_msb = alu_result[16];

  // in_ready is registered, so it first rises one edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= RUN;
      in_ready     <= 1'b0;
      rf_we        <= 1'b0;
      rf_waddr     <= '0;
      rf_wdata     <= 16'h0000;
      flags        <= 4'b0000;
      out_data     <= 16'h0000;
      out_valid    <= 1'b0;
      halted       <= 1'b0;
      retire_count <= 16'h0000;
    end else begin
      rf_we <= 1'b0;
      case (state)
        RUN: begin
          in_ready <= 1'b1;
          if (accept) begin
            retire_count <= retire_count + 16'd1;
            rf_waddr     <= rd;
            rf_wdata     <= alu_result[15:0];
            // HLT ignores the write, flag and OUT enables of its own instruction.
            if (is_hlt) begin
              state    <= HALT;
              halted   <= 1'b1;
              in_ready <= 1'b0;
            end else begin
              rf_we <= wb_en;
              if (flag_en) begin
                flags <= {alu_s, alu_z, alu_c, alu_v};
              end
              if (out_en) begin
                out_data  <= alu_result[15:0];
                out_valid <= 1'b1;
                in_ready  <= 1'b0;
                state     <= OUT_WAIT;
              end
            end
          end
        end
        OUT_WAIT: begin
          if (out_ack) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= RUN;
          end
        end
        HALT: begin
          in_ready <= 1'b0;
        end
        default: begin
          state    <= RUN;
          in_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule
